// File: rtl/host_cmd_sequencer.sv
// host_cmd_sequencer
//   Host-side command front end. Host command words are buffered in a FIFO
//   and replayed as single-cycle strobes on the program-load (prog_load_*)
//   and external-input (ext_*) interfaces of the downstream system top.
//   STIM performs inject, one low cycle, then trigger, entirely in hardware.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (see below)
//   cmd_data[79:0]      {opcode[3:0], node{y,x}[7:0], nid[3:0], addr[31:0], data[31:0]}
//   prog_load_enable    one-hot node select, high only in a PROG strobe cycle
//   prog_load_write     one-hot write strobe, same timing as prog_load_enable
//   prog_load_addr/data instruction address/word, held between strobes
//   ext_node_select     {y,x}, held between strobes
//   ext_neuron_id       neuron id, or trigger code nid*8+6, held between strobes
//   ext_input_current   current value, held between strobes
//   ext_input_valid     external input strobe
//   busy                FIFO non-empty or sequencer not idle
//   err_illegal         sticky; set whenever a command is dropped as illegal
//   fifo_count          FIFO occupancy
//
// Handshake: a word is accepted on every rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high whenever the FIFO is not full and
// does not depend on cmd_valid. cmd_data must be stable while cmd_valid is high.
module host_cmd_sequencer #(
  parameter int MESH_SIZE_X          = 2,
  parameter int MESH_SIZE_Y          = 2,
  parameter int NUM_NODES            = MESH_SIZE_X * MESH_SIZE_Y,
  parameter int NUM_NEURONS_PER_BANK = 4,
  parameter int FIFO_DEPTH           = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [79:0]                   cmd_data,
  output logic [NUM_NODES-1:0]          prog_load_enable,
  output logic [NUM_NODES-1:0]          prog_load_write,
  output logic [31:0]                   prog_load_addr,
  output logic [31:0]                   prog_load_data,
  output logic [7:0]                    ext_node_select,
  output logic [7:0]                    ext_neuron_id,
  output logic [31:0]                   ext_input_current,
  output logic                          ext_input_valid,
  output logic                          busy,
  output logic                          err_illegal,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_PROG   = 4'd1;
  localparam logic [3:0] OP_INJECT = 4'd2;
  localparam logic [3:0] OP_STIM   = 4'd3;
  localparam logic [3:0] OP_WAIT   = 4'd4;

  typedef enum logic [2:0] {S_IDLE, S_PULSE, S_GAP, S_TRIG, S_WAIT} state_t;

  // ---------------- command FIFO ----------------
  logic [79:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop;

  assign cmd_ready  = (count_q < CW'(FIFO_DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign fifo_count = count_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_data;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // ---------------- head-of-FIFO decode ----------------
  logic [79:0]          head;
  logic [3:0]           head_op, head_nid;
  logic [7:0]           head_node;
  logic [31:0]          head_addr, head_data;
  logic [NUM_NODES-1:0] head_onehot;
  logic                 prog_legal, ext_legal;

  assign head        = mem_q[rd_ptr_q];
  assign head_op     = head[79:76];
  assign head_node   = head[75:68];
  assign head_nid    = head[67:64];
  assign head_addr   = head[63:32];
  assign head_data   = head[31:0];
  assign head_onehot = NUM_NODES'(1) << head_node;
  assign prog_legal  = ({1'b0, head_node} < 9'(NUM_NODES));
  assign ext_legal   = ({1'b0, head_node[3:0]} < 5'(MESH_SIZE_X)) &&
                       ({1'b0, head_node[7:4]} < 5'(MESH_SIZE_Y)) &&
                       ({1'b0, head_nid}       < 5'(NUM_NEURONS_PER_BANK));

  // ---------------- sequencer ----------------
  state_t               state_q, state_d;
  logic                 is_prog_q, is_prog_d;
  logic                 trig_pend_q, trig_pend_d;
  logic [15:0]          wait_cnt_q, wait_cnt_d;
  logic                 err_q, err_d;
  logic [NUM_NODES-1:0] onehot_q, onehot_d;
  logic [31:0]          prog_addr_q, prog_addr_d, prog_data_q, prog_data_d;
  logic [7:0]           ext_node_q, ext_node_d, ext_nid_q, ext_nid_d;
  logic [31:0]          ext_cur_q, ext_cur_d;
  logic                 can_decode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      is_prog_q   <= 1'b0;
      trig_pend_q <= 1'b0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      onehot_q    <= '0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      ext_node_q  <= '0;
      ext_nid_q   <= '0;
      ext_cur_q   <= '0;
    end else begin
      state_q     <= state_d;
      is_prog_q   <= is_prog_d;
      trig_pend_q <= trig_pend_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      onehot_q    <= onehot_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      ext_node_q  <= ext_node_d;
      ext_nid_q   <= ext_nid_d;
      ext_cur_q   <= ext_cur_d;
    end
  end

  // A new command may be decoded whenever the current one is on its last
  // cycle (final GAP, last WAIT cycle) as well as in IDLE, so back-to-back
  // single-pulse commands run at one strobe every two cycles.
  always_comb begin
    state_d     = state_q;
    is_prog_d   = is_prog_q;
    trig_pend_d = trig_pend_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    onehot_d    = onehot_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    ext_node_d  = ext_node_q;
    ext_nid_d   = ext_nid_q;
    ext_cur_d   = ext_cur_q;
    can_decode  = 1'b0;
    pop         = 1'b0;

    case (state_q)
      S_PULSE: state_d = S_GAP;
      S_GAP: begin
        if (trig_pend_q) begin
          // Trigger code for the injected neuron: nid*8+6.
          state_d     = S_TRIG;
          trig_pend_d = 1'b0;
          ext_nid_d   = {ext_nid_q[4:0], 3'b110};
          ext_cur_d   = 32'h0000_0001;
        end else begin
          can_decode = 1'b1;
        end
      end
      S_TRIG: state_d = S_GAP;
      S_WAIT: begin
        if (wait_cnt_q > 16'd1) wait_cnt_d = wait_cnt_q - 16'd1;
        else                    can_decode = 1'b1;
      end
      default: can_decode = 1'b1;
    endcase

    if (can_decode) begin
      state_d = S_IDLE;
      if (count_q != '0) begin
        pop = 1'b1;
        case (head_op)
          OP_NOP: ;
          OP_PROG: begin
            if (prog_legal) begin
              state_d     = S_PULSE;
              is_prog_d   = 1'b1;
              onehot_d    = head_onehot;
              prog_addr_d = head_addr;
              prog_data_d = head_data;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_INJECT, OP_STIM: begin
            if (ext_legal) begin
              state_d     = S_PULSE;
              is_prog_d   = 1'b0;
              trig_pend_d = (head_op == OP_STIM);
              ext_node_d  = head_node;
              ext_nid_d   = {4'h0, head_nid};
              ext_cur_d   = head_data;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_WAIT: begin
            if (head_data[15:0] != 16'd0) begin
              state_d    = S_WAIT;
              wait_cnt_d = head_data[15:0];
            end
          end
          default: err_d = 1'b1;
        endcase
      end
    end
  end

  // Strobes are decoded from state so an asynchronous reset kills them at once.
  assign prog_load_write   = (state_q == S_PULSE && is_prog_q) ? onehot_q : '0;
  assign prog_load_enable  = prog_load_write;
  assign ext_input_valid   = (state_q == S_PULSE && !is_prog_q) || (state_q == S_TRIG);
  assign prog_load_addr    = prog_addr_q;
  assign prog_load_data    = prog_data_q;
  assign ext_node_select   = ext_node_q;
  assign ext_neuron_id     = ext_nid_q;
  assign ext_input_current = ext_cur_q;
  assign busy              = (count_q != '0) || (state_q != S_IDLE);
  assign err_illegal       = err_q;

endmodule
